// File: rtl/counter_seq_ctrl.sv
// Front-panel controller for the loadable counter: debounces KEY presses into load/step strobes
// and adds an auto-step RUN mode with stop detection. Define STEP_COUNT_EN to add the step_total output.
module counter_seq_ctrl #(
    parameter int WIDTH      = 4,
    parameter int DEB_CYCLES = 500000,
    parameter int RUN_DIV    = 25000000
) (
    input  logic             CLOCK_50,
    input  logic             RESET,
    input  logic             key_load_n,
    input  logic             key_step_n,
    input  logic             key_run_n,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] stop_val,
    input  logic             stop_en,
    input  logic [WIDTH-1:0] cnt_q,
    output logic             cnt_load,
    output logic [WIDTH-1:0] cnt_d,
    output logic             cnt_step,
    output logic             running,
    output logic             done
`ifdef STEP_COUNT_EN
    ,
    output logic [7:0]       step_total
`endif
);

    localparam int DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int DIV_W = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;

    typedef enum logic [2:0] {IDLE, LOAD, STEP, RUN, RUN_STEP} state_t;

    state_t             state_reg, state_next;
    logic [DIV_W-1:0]   div_reg, div_next;
    logic [WIDTH-1:0]   cnt_d_reg, cnt_d_next;
    logic               done_reg, done_next;
    logic [2:0]         key_raw_n;
    logic [2:0]         press_evt;
    logic               load_evt, step_evt, run_evt, tick;

    // Key index: 0 = load, 1 = step, 2 = run
    assign key_raw_n = {key_run_n, key_step_n, key_load_n};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_key
            logic             sync1_reg, sync2_reg, level_reg, level_prev_reg;
            logic [DEB_W-1:0] deb_cnt_reg;

            always_ff @(posedge CLOCK_50 or posedge RESET) begin
                if (RESET) begin
                    sync1_reg      <= 1'b1;
                    sync2_reg      <= 1'b1;
                    level_reg      <= 1'b1;
                    level_prev_reg <= 1'b1;
                    deb_cnt_reg    <= '0;
                end else begin
                    sync1_reg      <= key_raw_n[gi];
                    sync2_reg      <= sync1_reg;
                    level_prev_reg <= level_reg;
                    // Level flips only after DEB_CYCLES consecutive disagreeing samples
                    if (sync2_reg != level_reg) begin
                        if (deb_cnt_reg == DEB_W'(DEB_CYCLES - 1)) begin
                            level_reg   <= sync2_reg;
                            deb_cnt_reg <= '0;
                        end else begin
                            deb_cnt_reg <= deb_cnt_reg + DEB_W'(1);
                        end
                    end else begin
                        deb_cnt_reg <= '0;
                    end
                end
            end

            assign press_evt[gi] = level_prev_reg & ~level_reg;
        end
    endgenerate

    assign load_evt = press_evt[0];
    assign step_evt = press_evt[1];
    assign run_evt  = press_evt[2];
    assign tick     = (div_reg == DIV_W'(RUN_DIV - 1));

    always_comb begin
        state_next = state_reg;
        cnt_d_next = cnt_d_reg;
        done_next  = 1'b0;
        div_next   = '0;
        case (state_reg)
            IDLE: begin
                if (load_evt) begin
                    state_next = LOAD;
                    cnt_d_next = load_val;
                end else if (run_evt) begin
                    state_next = RUN;
                end else if (step_evt) begin
                    state_next = STEP;
                end
            end
            LOAD:     state_next = IDLE;
            STEP:     state_next = IDLE;
            RUN: begin
                div_next = tick ? '0 : div_reg + DIV_W'(1);
                // Key events outrank a coincident tick
                if (load_evt) begin
                    state_next = LOAD;
                    cnt_d_next = load_val;
                end else if (run_evt) begin
                    state_next = IDLE;
                end else if (tick) begin
                    if (stop_en && (cnt_q == stop_val)) begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end else begin
                        state_next = RUN_STEP;
                    end
                end
            end
            RUN_STEP: begin
                div_next   = div_reg + DIV_W'(1);
                state_next = RUN;
            end
            default:  state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            state_reg <= IDLE;
            div_reg   <= '0;
            cnt_d_reg <= '0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            div_reg   <= div_next;
            cnt_d_reg <= cnt_d_next;
            done_reg  <= done_next;
        end
    end

    assign cnt_load = (state_reg == LOAD);
    assign cnt_step = (state_reg == STEP) || (state_reg == RUN_STEP);
    assign running  = (state_reg == RUN) || (state_reg == RUN_STEP);
    assign cnt_d    = cnt_d_reg;
    assign done     = done_reg;

`ifdef STEP_COUNT_EN
    logic [7:0] step_total_reg;

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            step_total_reg <= '0;
        end else if (cnt_load) begin
            step_total_reg <= '0;
        end else if (cnt_step && (step_total_reg != 8'hFF)) begin
            step_total_reg <= step_total_reg + 8'd1;
        end
    end

    assign step_total = step_total_reg;
`endif

endmodule
